// File: rtl/ofdm_packet_detect_corr_if.sv
// Sample-pair stream into the delayed-autocorrelation detector
// plus the metric and frame-detect results coming back out.
interface ofdm_packet_detect_corr_if;
  logic              Buffer_Enable;
  logic signed [7:0] DataARe;
  logic signed [7:0] DataAIm;
  logic signed [7:0] DataBRe;
  logic signed [7:0] DataBIm;
  logic              Frame_Done;
  logic              CorrValid;
  logic [21:0]       CorrMetric;
  logic [19:0]       EnergyOut;
  logic              FrameFinded;

  modport master (
    output Buffer_Enable, DataARe, DataAIm,
    output DataBRe, DataBIm, Frame_Done,
    input  CorrValid, CorrMetric, EnergyOut,
    input  FrameFinded
  );

  modport slave (
    input  Buffer_Enable, DataARe, DataAIm,
    input  DataBRe, DataBIm, Frame_Done,
    output CorrValid, CorrMetric, EnergyOut,
    output FrameFinded
  );
endinterface

// File: rtl/ofdm_packet_detect_corr.sv
// Delayed-autocorrelation packet detector: 16-beat sliding
// correlation/energy, ratio threshold and run-length detect FSM.
module ofdm_packet_detect_corr #(
  parameter int WIN        = 16,
  parameter int THRESH_NUM = 6,
  parameter int HOLD_CNT   = 32,
  parameter int EMIN       = 1024
) (
  input  logic Clk,
  input  logic Rst_n,
  ofdm_packet_detect_corr_if.slave bus
);
  localparam int WCW  = $clog2(WIN);
  localparam int RUNW = $clog2(HOLD_CNT + 1);

  typedef enum logic [1:0] {
    S_WARM,
    S_SRCH,
    S_FOUND
  } state_t;

  state_t r_state, w_nstate;
  logic [WCW-1:0]  r_wcnt, w_nwcnt;
  logic [RUNW-1:0] r_run, w_nrun, w_runinc;
  logic            w_flush;

  assign w_flush = (r_state == S_FOUND) && bus.Frame_Done;

  // Stage 1: conj product and power of the current sample
  logic signed [15:0] w_ar, w_ai, w_br, w_bi;
  logic signed [15:0] w_rr, w_ii, w_ir, w_ri;
  logic signed [15:0] w_sqr, w_sqi;
  logic signed [16:0] w_pre, w_pim;
  logic [15:0]        w_q;

  assign w_ar  = 16'(bus.DataARe);
  assign w_ai  = 16'(bus.DataAIm);
  assign w_br  = 16'(bus.DataBRe);
  assign w_bi  = 16'(bus.DataBIm);
  assign w_rr  = w_ar * w_br;
  assign w_ii  = w_ai * w_bi;
  assign w_ir  = w_ai * w_br;
  assign w_ri  = w_ar * w_bi;
  assign w_sqr = w_ar * w_ar;
  assign w_sqi = w_ai * w_ai;
  assign w_pre = {w_rr[15], w_rr} + {w_ii[15], w_ii};
  assign w_pim = {w_ir[15], w_ir} - {w_ri[15], w_ri};
  assign w_q   = $unsigned(w_sqr) + $unsigned(w_sqi);

  logic               r_v1;
  logic signed [16:0] r_pre, r_pim;
  logic [15:0]        r_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_v1  <= 1'b0;
      r_pre <= '0;
      r_pim <= '0;
      r_q   <= '0;
    end else begin
      r_v1 <= bus.Buffer_Enable && !w_flush;
      if (bus.Buffer_Enable) begin
        r_pre <= w_pre;
        r_pim <= w_pim;
        r_q   <= w_q;
      end
    end
  end

  // Stage 2: sliding window sums over a WIN-deep delay line
  logic signed [16:0] r_dl_re [WIN];
  logic signed [16:0] r_dl_im [WIN];
  logic [15:0]        r_dl_q  [WIN];
  logic signed [20:0] r_cre, r_cim;
  logic [19:0]        r_e;
  logic               r_v2;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < WIN; i++) begin
        r_dl_re[i] <= '0;
        r_dl_im[i] <= '0;
        r_dl_q[i]  <= '0;
      end
      r_cre <= '0;
      r_cim <= '0;
      r_e   <= '0;
      r_v2  <= 1'b0;
    end else if (w_flush) begin
      for (int i = 0; i < WIN; i++) begin
        r_dl_re[i] <= '0;
        r_dl_im[i] <= '0;
        r_dl_q[i]  <= '0;
      end
      r_cre <= '0;
      r_cim <= '0;
      r_e   <= '0;
      r_v2  <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_dl_re[0] <= r_pre;
        r_dl_im[0] <= r_pim;
        r_dl_q[0]  <= r_q;
        for (int i = 1; i < WIN; i++) begin
          r_dl_re[i] <= r_dl_re[i-1];
          r_dl_im[i] <= r_dl_im[i-1];
          r_dl_q[i]  <= r_dl_q[i-1];
        end
        r_cre <= r_cre
               + {{4{r_pre[16]}}, r_pre}
               - {{4{r_dl_re[WIN-1][16]}}, r_dl_re[WIN-1]};
        r_cim <= r_cim
               + {{4{r_pim[16]}}, r_pim}
               - {{4{r_dl_im[WIN-1][16]}}, r_dl_im[WIN-1]};
        r_e   <= r_e + {4'd0, r_q} - {4'd0, r_dl_q[WIN-1]};
      end
    end
  end

  // Stage 3: alpha-max/beta-min magnitude and ratio test
  logic [20:0] w_acre, w_acim, w_mx, w_mn;
  logic [21:0] w_m;
  logic [24:0] w_lhs, w_rhs;
  logic        w_hit;

  assign w_acre = r_cre[20] ? (~r_cre + 21'd1) : r_cre;
  assign w_acim = r_cim[20] ? (~r_cim + 21'd1) : r_cim;
  assign w_mx   = (w_acre >= w_acim) ? w_acre : w_acim;
  assign w_mn   = (w_acre >= w_acim) ? w_acim : w_acre;
  assign w_m    = {1'b0, w_mx} + 22'(w_mn >> 1);
  assign w_lhs  = {w_m, 3'b000};
  assign w_rhs  = {5'd0, r_e} * 25'(THRESH_NUM);
  assign w_hit  = (r_e >= 20'(EMIN)) && (w_lhs >= w_rhs);

  logic        r_cvalid, r_hit;
  logic [21:0] r_metric;
  logic [19:0] r_energy;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cvalid <= 1'b0;
      r_hit    <= 1'b0;
      r_metric <= '0;
      r_energy <= '0;
    end else begin
      r_cvalid <= r_v2 && !w_flush;
      if (r_v2 && !w_flush) begin
        r_hit    <= w_hit;
        r_metric <= w_m;
        r_energy <= r_e;
      end
    end
  end

  // Detection FSM
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_WARM;
      r_wcnt  <= '0;
      r_run   <= '0;
    end else begin
      r_state <= w_nstate;
      r_wcnt  <= w_nwcnt;
      r_run   <= w_nrun;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_nwcnt  = r_wcnt;
    w_nrun   = r_run;
    w_runinc = r_run + 1'b1;
    unique case (r_state)
      S_WARM: begin
        if (r_cvalid) begin
          w_nwcnt = r_wcnt + 1'b1;
          if (r_wcnt == WCW'(WIN - 1)) begin
            w_nstate = S_SRCH;
            w_nrun   = r_hit ? RUNW'(1) : '0;
          end
        end
      end
      S_SRCH: begin
        if (r_cvalid) begin
          if (!r_hit) begin
            w_nrun = '0;
          end else begin
            w_nrun = w_runinc;
            if (w_runinc == RUNW'(HOLD_CNT))
              w_nstate = S_FOUND;
          end
        end
      end
      S_FOUND: begin
        if (bus.Frame_Done) begin
          w_nstate = S_WARM;
          w_nwcnt  = '0;
          w_nrun   = '0;
        end
      end
      default: begin
        w_nstate = S_WARM;
        w_nwcnt  = '0;
        w_nrun   = '0;
      end
    endcase
  end

  assign bus.CorrValid   = r_cvalid;
  assign bus.CorrMetric  = r_metric;
  assign bus.EnergyOut   = r_energy;
  assign bus.FrameFinded = (r_state == S_FOUND);
endmodule

// File: tb/tb_ofdm_packet_detect_corr.sv
// Bench for the packet detector: window-sum reference model
// checked every cycle, plus hand-computed directed expectations.
module tb_ofdm_packet_detect_corr;
  localparam int WIN  = 16;
  localparam int THR  = 6;
  localparam int HOLD = 32;
  localparam int EMIN = 1024;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  ofdm_packet_detect_corr_if bus();

  ofdm_packet_detect_corr #(
    .WIN(WIN), .THRESH_NUM(THR),
    .HOLD_CNT(HOLD), .EMIN(EMIN)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .bus(bus)
  );

  typedef struct {int re; int im; int q;} prod_t;
  typedef struct {int m; int e; bit hit; int cyc;} exp_t;

  int n_chk = 0;
  int n_fail = 0;
  prod_t hist[$];
  exp_t  expq[$];
  int    mlog[$];
  int    elog[$];
  int    refm[$];
  int    cyc = 0;
  int    nbeat = 0;
  int    run = 0;
  int    det_idx = -1;
  bit    exp_ff = 1'b0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: explicit window sums over the beat history
  always @(negedge Clk) begin
    exp_t  ex;
    prod_t p;
    int    cre, cim, e, acr, aci, m, ar, ai, br, bi;
    bit    fd, nxt_ff;
    cyc++;
    if (!Rst_n) begin
      hist.delete();
      expq.delete();
      run = 0;
      nbeat = 0;
      exp_ff = 1'b0;
      det_idx = -1;
    end else begin
      chk("FrameFinded", bus.FrameFinded, exp_ff);
      fd = bus.Frame_Done && exp_ff;
      nxt_ff = exp_ff;
      if (!bus.CorrValid && expq.size() > 0
          && cyc - expq[0].cyc >= 3) begin
        chk("CorrValid missing", bus.CorrValid, 1);
        ex = expq.pop_front();
      end
      if (bus.CorrValid) begin
        if (expq.size() == 0) begin
          chk("CorrValid spurious", bus.CorrValid, 0);
        end else begin
          ex = expq.pop_front();
          chk("CorrValid latency", cyc - ex.cyc, 3);
          chk("CorrMetric", bus.CorrMetric, ex.m);
          chk("EnergyOut", bus.EnergyOut, ex.e);
          mlog.push_back(int'(bus.CorrMetric));
          elog.push_back(int'(bus.EnergyOut));
          if (!fd && !exp_ff) begin
            if (nbeat >= WIN - 1)
              run = ex.hit ? run + 1 : 0;
            if (run == HOLD) begin
              nxt_ff = 1'b1;
              det_idx = nbeat;
            end
          end
          nbeat++;
        end
      end
      if (bus.Buffer_Enable) begin
        ar = int'(bus.DataARe);
        ai = int'(bus.DataAIm);
        br = int'(bus.DataBRe);
        bi = int'(bus.DataBIm);
        p.re = ar * br + ai * bi;
        p.im = ai * br - ar * bi;
        p.q  = ar * ar + ai * ai;
        hist.push_back(p);
        if (hist.size() > WIN) p = hist.pop_front();
        cre = 0; cim = 0; e = 0;
        foreach (hist[k]) begin
          cre += hist[k].re;
          cim += hist[k].im;
          e   += hist[k].q;
        end
        acr = (cre < 0) ? -cre : cre;
        aci = (cim < 0) ? -cim : cim;
        m = (acr > aci) ? acr + aci / 2 : aci + acr / 2;
        ex.m = m;
        ex.e = e;
        ex.hit = (e >= EMIN) && (8 * m >= THR * e);
        ex.cyc = cyc;
        expq.push_back(ex);
      end
      if (fd) begin
        hist.delete();
        expq.delete();
        run = 0;
        nbeat = 0;
        nxt_ff = 1'b0;
      end
      exp_ff = nxt_ff;
    end
  end

  task automatic drive(input int ar, input int ai,
                       input int br, input int bi,
                       input int gap);
    repeat (gap) begin
      @(posedge Clk);
      #1 bus.Buffer_Enable = 1'b0;
    end
    @(posedge Clk);
    #1;
    bus.Buffer_Enable = 1'b1;
    bus.DataARe = 8'(ar);
    bus.DataAIm = 8'(ai);
    bus.DataBRe = 8'(br);
    bus.DataBIm = 8'(bi);
  endtask

  task automatic drive_p(input int i, input int gap);
    drive((i * 29) % 120 - 60, (i * 53) % 100 - 50,
          (i * 17 + 5) % 110 - 55, (i * 41) % 90 - 45, gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1 bus.Buffer_Enable = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #2;
    bus.Buffer_Enable = 1'b0;
    Rst_n = 1'b0;
    #1;
    chk("async rst FrameFinded", bus.FrameFinded, 0);
    chk("async rst CorrMetric", bus.CorrMetric, 0);
    chk("async rst EnergyOut", bus.EnergyOut, 0);
    chk("async rst CorrValid", bus.CorrValid, 0);
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    mlog.delete();
    elog.delete();
  endtask

  initial begin
    bus.Buffer_Enable = 1'b0;
    bus.Frame_Done = 1'b0;
    bus.DataARe = '0;
    bus.DataAIm = '0;
    bus.DataBRe = '0;
    bus.DataBIm = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset CorrValid", bus.CorrValid, 0);
    chk("reset CorrMetric", bus.CorrMetric, 0);
    chk("reset EnergyOut", bus.EnergyOut, 0);
    chk("reset FrameFinded", bus.FrameFinded, 0);
    Rst_n = 1'b1;

    // constant A=B=(64,0)
    for (int i = 0; i < 60; i++) drive(64, 0, 64, 0, 0);
    idle(6);
    chk("const partial M", mlog[14], 61440);
    chk("const full M", mlog[15], 65536);
    chk("const full E", elog[15], 65536);
    chk("const detect beat", det_idx, 46);
    chk("const found", bus.FrameFinded, 1);

    // reset from FOUND, then from SEARCH, then re-detect
    do_reset();
    for (int i = 0; i < 30; i++) drive(64, 0, 64, 0, 0);
    do_reset();
    for (int i = 0; i < 60; i++) drive(64, 0, 64, 0, 0);
    idle(6);
    chk("post-reset detect beat", det_idx, 46);

    // all-zero input
    do_reset();
    for (int i = 0; i < 1000; i++) drive(0, 0, 0, 0, 0);
    idle(6);
    chk("zero detect", det_idx, -1);
    chk("zero E", elog[500], 0);

    // B alternating sign
    do_reset();
    for (int i = 0; i < 100; i++)
      drive(64, 0, (i % 2 == 1) ? -64 : 64, 0, 0);
    idle(6);
    chk("alt M beat15", mlog[15], 0);
    chk("alt M beat60", mlog[60], 0);
    chk("alt detect", det_idx, -1);

    // single zero beat at 30
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if (i == 30) drive(0, 0, 0, 0, 0);
      else drive(64, 0, 64, 0, 0);
    end
    idle(6);
    chk("hole M beat30", mlog[30], 61440);
    chk("hole E beat30", elog[30], 61440);
    chk("hole M beat45", mlog[45], 61440);
    chk("hole M beat46", mlog[46], 65536);
    chk("hole detect beat", det_idx, 46);

    // B inverted for beats 30-45: run clears at 32
    do_reset();
    for (int i = 0; i < 120; i++)
      drive(64, 0, (i >= 30 && i <= 45) ? -64 : 64, 0, 0);
    idle(6);
    chk("inv M beat31", mlog[31], 49152);
    chk("inv M beat32", mlog[32], 40960);
    chk("inv detect beat", det_idx, 90);

    // gap independence
    do_reset();
    for (int i = 0; i < 64; i++) drive_p(i, 0);
    idle(6);
    refm = mlog;
    do_reset();
    for (int i = 0; i < 64; i++) drive_p(i, $urandom_range(0, 3));
    idle(6);
    chk("gap seq length", mlog.size(), refm.size());
    foreach (refm[i]) chk("gap seq metric", mlog[i], refm[i]);

    // detect with gaps, Frame_Done, re-detect
    do_reset();
    for (int i = 0; i < 60; i++)
      drive(64, 0, 64, 0, $urandom_range(0, 3));
    idle(6);
    chk("gap detect beat", det_idx, 46);
    @(posedge Clk);
    #1 bus.Frame_Done = 1'b1;
    @(posedge Clk);
    #1 bus.Frame_Done = 1'b0;
    chk("Frame_Done clears", bus.FrameFinded, 0);
    det_idx = -1;
    mlog.delete();
    for (int i = 0; i < 46; i++)
      drive(64, 0, 64, 0, $urandom_range(0, 3));
    idle(6);
    chk("redetect not early", det_idx, -1);
    chk("redetect not early FF", bus.FrameFinded, 0);
    drive(64, 0, 64, 0, 0);
    idle(6);
    chk("redetect beat", det_idx, 46);
    chk("redetect FF", bus.FrameFinded, 1);

    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ofdm_packet_detect_corr.md
# ofdm_packet_detect_corr

Delayed-autocorrelation packet detector for the OFDM receiver, downstream of the packet-detection data buffer. It consumes the paired current and 16-sample-delayed complex samples and forms a 16-sample sliding-window correlation and energy. A threshold state machine then asserts `FrameFinded`, which drives the buffer's output gating. Detection requires a minimum run of consecutive over-threshold windows.

## Interface
- `WIN`, 16: correlation/energy window length in valid beats; power of two, fixed at 16 for the widths below.
- `THRESH_NUM`, 6: threshold numerator. A window is a hit when `8*M >= THRESH_NUM*E`, i.e. ratio 0.75 by default.
- `HOLD_CNT`, 32: number of consecutive hits required to declare a frame.
- `EMIN`, 1024: minimum window energy; windows with `E < EMIN` are never hits.
- `Clk` in 1: clock.
- `Rst_n` in 1: reset, asynchronous, active-low.
- `Buffer_Enable` in 1: sample pair valid.
- `DataARe`, `DataAIm` in 8 each: current sample, signed Q1.6.
- `DataBRe`, `DataBIm` in 8 each: sample delayed 16 beats, signed Q1.6.
- `Frame_Done` in 1: single-cycle pulse from the downstream frame processor ending the current frame.
- `CorrValid` out 1: metric outputs valid this cycle.
- `CorrMetric` out 22: magnitude approximation M, unsigned.
- `EnergyOut` out 20: window energy E, unsigned.
- `FrameFinded` out 1: frame detected; level, held until `Frame_Done`.

## Operation
- Stage 1, registered on each `Buffer_Enable` beat:
  - `PRe = ARe*BRe + AIm*BIm` (17b signed).
  - `PIm = AIm*BRe - ARe*BIm` (17b signed).
  - `Q = ARe^2 + AIm^2` (16b unsigned, max 32768).
- Stage 2, sliding sums, advancing only on valid beats:
  - A 16-deep delay line of {PRe, PIm, Q} feeds the accumulators.
  - `CRe/CIm` (21b signed) `+= new - oldest`; `E` (20b unsigned) likewise.
  - Delay-line entries reset to 0, so partial windows are exact sums of the samples received so far.
- Stage 3:
  - `M = max(|CRe|,|CIm|) + (min(|CRe|,|CIm|) >> 1)`, truncating.
  - `hit = (E >= EMIN) && ({M,3'b0} >= E*THRESH_NUM)`, compared at 25b.
- FSM, with states updating only on stage-3 valid beats except where noted:
  - **WARMUP** (reset state): count beats entering the window; after the WIN-th beat reaches stage 3, go to SEARCH. That beat is evaluated in SEARCH, so the first full window can be hit #1.
  - **SEARCH**: a hit increments `run`, a non-hit clears it. When `run` reaches `HOLD_CNT`, go to FOUND and set `FrameFinded`=1.
  - **FOUND**: `FrameFinded` stays 1 and metrics keep streaming; hits are ignored.
  - `Frame_Done` in FOUND takes effect on any cycle, independent of valid. It clears `FrameFinded`, `run`, the accumulators and the delay line, and goes to WARMUP.
  - `Frame_Done` in WARMUP or SEARCH is ignored.
- Gaps in `Buffer_Enable` freeze all pipeline data and counters. Results are identical with or without gaps.
- Saturation is not needed: widths cover the worst case `16 * 32768`.

## Timing
- Beat accepted at cycle t:
  - stage-1 registers at t+1;
  - accumulators at t+2;
  - `CorrValid`, `CorrMetric`, `EnergyOut` at t+3;
  - `FrameFinded` rises at t+4 for the beat producing hit `HOLD_CNT`.
- `CorrValid` is a 1-cycle pulse per beat. Metric outputs hold their last value when `CorrValid`=0.
- `Frame_Done` at cycle t: `FrameFinded`=0 at t+1. Any beats in flight in the pipeline are flushed (`CorrValid` suppressed).
- If `Frame_Done` and `CorrValid` occur in the same cycle, `Frame_Done` wins.
- Reset values: all outputs 0, FSM in WARMUP, `run`=0, accumulators and delay line 0. Reset asserted mid-frame forces `FrameFinded`=0 immediately, asynchronously.

## Test plan
- **Reset mid-SEARCH**: assert `Rst_n`=0 -> all outputs 0 at once; after release, 16 beats are needed before any hit is counted.
- **Constant A=B=(64,0), continuous enable** -> window beat 16 gives `CRe`=65536, `CIm`=0, `E`=65536, `CorrMetric`=65536 (hit). `FrameFinded` rises 4 cycles after beat 47 (hit #32).
- **All-zero input** -> `E`=0 < `EMIN`, so no hits; `FrameFinded` never asserts over 1000 beats.
- **A=(64,0), B alternating (64,0)/(-64,0)** -> `CorrMetric`=0 on every full window; no detection.
- **Constant input with one beat of A=B=(0,0) at beat 30** -> the zero beat is in the window for 16 beats, giving `E`=61440 and `CorrMetric`=61440 (still a hit). Repeat with B inverted for beats 30-45 -> `run` clears, and detection is delayed accordingly; check that the exact rise cycle matches the model.
- **Random 0-3 cycle gaps in `Buffer_Enable`** -> `CorrMetric` sequence matches the gapless run. Then pulse `Frame_Done` in FOUND -> `FrameFinded`=0 next cycle and re-detection requires 16+31 further beats.
